// File: rtl/sprite_oam_dma_pkg.sv
// Shared PPU definitions for the sprite OAM DMA engine: AHB-Lite transfer
// encodings, fixed transfer attributes, the copy FSM state encoding and an
// address helper used by the datapath.
package sprite_oam_dma_pkg;

  // AHB-Lite transfer type encodings; this initiator only ever issues these two
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Every transfer is a single 32-bit word, non-cacheable privileged data access
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  // One read (address + data phase) then one write (address + data phase) per word
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_FINISH  = 3'd5
  } dma_state_e;

  // Byte address of word 'index' above 'base'; wraps modulo 2^32 by construction
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
    return base + (index << 2);
  endfunction

endpackage

// File: rtl/sprite_oam_dma.sv
// Sprite OAM DMA: AHB-Lite initiator that copies 2^ADDR_WIDTH words from a
// source buffer into sprite RAM at SPRITE_BASE, one read/write pair per word.
// Optional build macro SPRITE_DMA_VSYNC_TRIG_EN lets the PPU end-of-frame
// pulse (VGA_Intr) start a copy while idle; without it VGA_Intr is ignored.
module sprite_oam_dma
  import sprite_oam_dma_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 6,
  parameter logic [31:0] SPRITE_BASE = 32'h5000_0000
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic        VGA_Intr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int unsigned          WORDS    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  LAST_IDX = (ADDR_WIDTH + 1)'(WORDS - 1);
  localparam logic [ADDR_WIDTH:0]  IDX_ONE  = (ADDR_WIDTH + 1)'(1);

  dma_state_e            state;
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH:0]   idx_next;
  logic [31:0]           idx_next_ext;
  logic [31:0]           src_base;
  logic [31:0]           data_q;
  logic                  trigger;

  assign idx_next     = idx + IDX_ONE;
  assign idx_next_ext = 32'(idx_next);

  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DATA;

`ifdef SPRITE_DMA_VSYNC_TRIG_EN
  // Either request source starts a copy; coincident requests still give one copy
  assign trigger = start | VGA_Intr;
`else
  logic unused_vga_intr;
  assign trigger         = start;
  assign unused_vga_intr = VGA_Intr;
`endif

  // Copy FSM with registered AHB outputs; next-phase address/control is loaded on
  // each transition so it is stable for the whole (possibly wait-stated) phase
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      HTRANS   <= HTRANS_IDLE;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HWDATA   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      idx      <= '0;
      src_base <= '0;
      data_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            src_base <= src_addr;
            idx      <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            HADDR    <= src_addr;
            HTRANS   <= HTRANS_NONSEQ;
            HWRITE   <= 1'b0;
            state    <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            state  <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (HRESP) begin
            err    <= 1'b1;
            busy   <= 1'b0;
            HTRANS <= HTRANS_IDLE;
            HWRITE <= 1'b0;
            state  <= ST_IDLE;
          end else if (HREADY) begin
            data_q <= HRDATA;
            HADDR  <= word_addr(SPRITE_BASE, 32'(idx));
            HTRANS <= HTRANS_NONSEQ;
            HWRITE <= 1'b1;
            state  <= ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            HWDATA <= data_q;
            state  <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (HRESP) begin
            err    <= 1'b1;
            busy   <= 1'b0;
            HTRANS <= HTRANS_IDLE;
            HWRITE <= 1'b0;
            state  <= ST_IDLE;
          end else if (HREADY) begin
            idx    <= idx_next;
            HWRITE <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FINISH;
            end else begin
              HADDR  <= word_addr(src_base, idx_next_ext);
              HTRANS <= HTRANS_NONSEQ;
              state  <= ST_RD_ADDR;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
